// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: connection bundle between the VGA timing core and the
// pixel generator / pin consumer. The master side is the timing core.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned RGB_W = 16
);

    logic [RGB_W-1:0] RGB_IN;
    logic             TP_SEL;
    logic             PIX_EN;
    logic [CNT_W-1:0] CNT_X;
    logic [CNT_W-1:0] CNT_Y;
    logic             VIDEO_ON;
    logic             FRAME_START;
    logic             LINE_END;
    logic             HSYNC;
    logic             VSYNC;
    logic [RGB_W-1:0] RGB;

    modport master (
        input  RGB_IN,
        input  TP_SEL,
        output PIX_EN,
        output CNT_X,
        output CNT_Y,
        output VIDEO_ON,
        output FRAME_START,
        output LINE_END,
        output HSYNC,
        output VSYNC,
        output RGB
    );

    modport slave (
        output RGB_IN,
        output TP_SEL,
        input  PIX_EN,
        input  CNT_X,
        input  CNT_Y,
        input  VIDEO_ON,
        input  FRAME_START,
        input  LINE_END,
        input  HSYNC,
        input  VSYNC,
        input  RGB
    );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing core with pixel-clock enable,
// raster counters, and registered HSYNC/VSYNC/RGB pins (RGB blanked outside
// the visible area). Pins show pixel (x,y) one pixel period after the
// counters present (x,y).
// Optional feature: define VGA_TEST_PATTERN_EN to let TP_SEL=1 replace
// RGB_IN with eight vertical colour bars.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned RGB_W    = 16
) (
    input logic              CLK,
    input logic              RESET,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic [CNT_W-1:0] cnt_x;
    logic [CNT_W-1:0] cnt_y;
    logic             x_last;
    logic             y_last;
    logic             video_on;
    logic             hsync_act;
    logic             vsync_act;
    logic [RGB_W-1:0] pix;
    logic             hsync_q;
    logic             vsync_q;
    logic [RGB_W-1:0] rgb_q;

    // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pixel enable on the last divider phase. Gated by RESET so that with
    // CLK_DIV=1 it still reads low while reset is held.
    always_comb begin
        pix_en = !RESET && (div_cnt == DIV_LAST);
    end

    // Raster position decode used by the counters and the strobes.
    always_comb begin
        x_last    = (cnt_x == X_LAST);
        y_last    = (cnt_y == Y_LAST);
        video_on  = (cnt_x < X_VIS) && (cnt_y < Y_VIS);
        hsync_act = (cnt_x >= HS_START) && (cnt_x < HS_END);
        vsync_act = (cnt_y >= VS_START) && (cnt_y < VS_END);
    end

    // Raster counters: X runs every pixel, Y advances when X wraps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (pix_en) begin
            if (x_last) begin
                cnt_x <= '0;
                if (y_last) begin
                    cnt_y <= '0;
                end else begin
                    cnt_y <= cnt_y + 1'b1;
                end
            end else begin
                cnt_x <= cnt_x + 1'b1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned FIELD_W = RGB_W / 3;
    localparam logic [CNT_W-1:0] BAR_DIV =
        CNT_W'((H_ACTIVE / 8) > 0 ? (H_ACTIVE / 8) : 1);

    logic [2:0]       bar;
    logic [RGB_W-1:0] bar_rgb;

    // Colour bars: blue field from bar[0], green from bar[1], and the
    // remaining top bits from bar[2] so bar 7 is all ones.
    always_comb begin
        bar = 3'(cnt_x / BAR_DIV);
        bar_rgb = '0;
        for (int unsigned i = 0; i < RGB_W; i++) begin
            if (i < FIELD_W) begin
                bar_rgb[i] = bar[0];
            end else if (i < 2 * FIELD_W) begin
                bar_rgb[i] = bar[1];
            end else begin
                bar_rgb[i] = bar[2];
            end
        end
    end

    // Pixel source select between generator input and colour bars.
    always_comb begin
        pix = vga.TP_SEL ? bar_rgb : vga.RGB_IN;
    end
`else
    logic unused_tp_sel;
    assign unused_tp_sel = vga.TP_SEL;

    // Pixel source is always the generator input.
    always_comb begin
        pix = vga.RGB_IN;
    end
`endif

    // Pin stage: sync and colour registered from the pre-update counters so
    // all three pins stay aligned one pixel behind the counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            rgb_q   <= '0;
        end else if (pix_en) begin
            hsync_q <= hsync_act ? H_POL : ~H_POL;
            vsync_q <= vsync_act ? V_POL : ~V_POL;
            rgb_q   <= video_on ? pix : '0;
        end
    end

    assign vga.PIX_EN      = pix_en;
    assign vga.CNT_X       = cnt_x;
    assign vga.CNT_Y       = cnt_y;
    assign vga.VIDEO_ON    = video_on;
    assign vga.LINE_END    = pix_en && x_last;
    assign vga.FRAME_START = pix_en && x_last && y_last;
    assign vga.HSYNC       = hsync_q;
    assign vga.VSYNC       = vsync_q;
    assign vga.RGB         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small-mode instances (CLK_DIV=2 active-low syncs,
// CLK_DIV=1 active-high syncs) checked every cycle against a raster model
// built from pixel-count arithmetic, with random RGB_IN/TP_SEL.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = 10;
    localparam int RW = 16;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP_ON = 1'b1;
`else
    localparam bit TP_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    vga_timing_gen_if #(.CNT_W(CW), .RGB_W(RW)) bus_a ();
    vga_timing_gen_if #(.CNT_W(CW), .RGB_W(RW)) bus_b ();

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CNT_W(CW), .RGB_W(RW)
    ) dut_a (.CLK(CLK), .RESET(RESET), .vga(bus_a));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(CW), .RGB_W(RW)
    ) dut_b (.CLK(CLK), .RESET(RESET), .vga(bus_b));

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model state: k = clock edges since the last reset edge.
    int          k[2];
    int          dv[2]  = '{2, 1};
    logic        pol[2] = '{1'b0, 1'b1};
    logic        e_hs[2];
    logic        e_vs[2];
    logic [RW-1:0] e_rgb[2];
    logic [RW-1:0] rin[2];
    logic        tp[2];

    // Frame statistics for instance A.
    bit clean = 1'b0;
    int clk_cnt = 0, lines = 0, hs_act = 0, vs_act = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] pixval(input int x, input logic t, input logic [RW-1:0] in);
        logic [RW-1:0] c;
        int bar;
        if (TP_ON && t) begin
            bar = x / (HA / 8);
            c = '0;
            if ((bar & 1) != 0) c = c | 16'h001F;
            if ((bar & 2) != 0) c = c | 16'h03E0;
            if ((bar & 4) != 0) c = c | 16'hFC00;
            return c;
        end
        return in;
    endfunction

    task automatic check_dut(input int d, input logic pix, input logic [CW-1:0] cx,
                             input logic [CW-1:0] cy, input logic von, input logic fs,
                             input logic le, input logic hs, input logic vs,
                             input logic [RW-1:0] rgb);
        int p, x, y;
        logic e_pix;
        p = k[d] / dv[d];
        x = p % HT;
        y = (p / HT) % VT;
        e_pix = !RESET && ((k[d] % dv[d]) == dv[d] - 1);
        chk($sformatf("d%0d pix_en", d), 32'(pix), 32'(e_pix));
        chk($sformatf("d%0d cnt_x", d), 32'(cx), x);
        chk($sformatf("d%0d cnt_y", d), 32'(cy), y);
        chk($sformatf("d%0d video_on", d), 32'(von), 32'((x < HA) && (y < VA)));
        chk($sformatf("d%0d line_end", d), 32'(le), 32'(e_pix && (x == HT - 1)));
        chk($sformatf("d%0d frame_start", d), 32'(fs),
            32'(e_pix && (x == HT - 1) && (y == VT - 1)));
        chk($sformatf("d%0d hsync", d), 32'(hs), 32'(e_hs[d]));
        chk($sformatf("d%0d vsync", d), 32'(vs), 32'(e_vs[d]));
        chk($sformatf("d%0d rgb", d), 32'(rgb), 32'(e_rgb[d]));
        if (d == 0) begin
            clk_cnt++;
            if (RESET) clean = 1'b0;
            if (pix === 1'b1) begin
                if (le === 1'b1) lines++;
                if (hs === 1'b0) hs_act++;
                if (vs === 1'b0) vs_act++;
            end
            if (fs === 1'b1) begin
                if (clean) begin
                    chk("a frame clocks", clk_cnt, HT * VT * 2);
                    chk("a lines per frame", lines, VT);
                    chk("a hsync active pixels", hs_act, VT * HS);
                    chk("a vsync active pixels", vs_act, HT * VS);
                end
                clean = 1'b1;
                clk_cnt = 0;
                lines = 0;
                hs_act = 0;
                vs_act = 0;
            end
        end
    endtask

    task automatic cycle(input logic rst_next);
        int p, x, y;
        @(negedge CLK);
        check_dut(0, bus_a.PIX_EN, bus_a.CNT_X, bus_a.CNT_Y, bus_a.VIDEO_ON,
                  bus_a.FRAME_START, bus_a.LINE_END, bus_a.HSYNC, bus_a.VSYNC, bus_a.RGB);
        check_dut(1, bus_b.PIX_EN, bus_b.CNT_X, bus_b.CNT_Y, bus_b.VIDEO_ON,
                  bus_b.FRAME_START, bus_b.LINE_END, bus_b.HSYNC, bus_b.VSYNC, bus_b.RGB);
        RESET = rst_next;
        rin[0] = RW'($urandom);
        rin[1] = RW'($urandom);
        tp[0] = 1'($urandom_range(0, 1));
        tp[1] = 1'($urandom_range(0, 1));
        bus_a.RGB_IN = rin[0];
        bus_a.TP_SEL = tp[0];
        bus_b.RGB_IN = rin[1];
        bus_b.TP_SEL = tp[1];
        for (int d = 0; d < 2; d++) begin
            if (rst_next) begin
                k[d] = 0;
                e_hs[d] = ~pol[d];
                e_vs[d] = ~pol[d];
                e_rgb[d] = '0;
            end else begin
                if ((k[d] % dv[d]) == dv[d] - 1) begin
                    p = k[d] / dv[d];
                    x = p % HT;
                    y = (p / HT) % VT;
                    e_hs[d] = (x >= HA + HF && x < HA + HF + HS) ? pol[d] : ~pol[d];
                    e_vs[d] = (y >= VA + VF && y < VA + VF + VS) ? pol[d] : ~pol[d];
                    e_rgb[d] = (x < HA && y < VA) ? pixval(x, tp[d], rin[d]) : '0;
                end
                k[d]++;
            end
        end
    endtask

    initial begin
        int guard;
        bus_a.RGB_IN = '0;
        bus_a.TP_SEL = 1'b0;
        bus_b.RGB_IN = '0;
        bus_b.TP_SEL = 1'b0;
        for (int d = 0; d < 2; d++) begin
            k[d] = 0;
            e_hs[d] = ~pol[d];
            e_vs[d] = ~pol[d];
            e_rgb[d] = '0;
        end

        // Reset held for 10 cycles, then released.
        repeat (9) cycle(1'b1);
        cycle(1'b0);

        // Several frames of free running with random pixel data.
        repeat (600) cycle(1'b0);

        // Single-cycle reset in the middle of a frame on instance A at (5,3).
        guard = 0;
        while ((((k[0] / 2) % (HT * VT)) != 3 * HT + 5 || (k[0] % 2) != 1) && guard < 400) begin
            cycle(1'b0);
            guard++;
        end
        chk("mid-frame position reached", 32'(guard < 400), 32'd1);
        cycle(1'b1);

        // Counting restarts from (0,0) after release.
        repeat (500) cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
